mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  EX-stage result valid.
REQ-005 in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
REQ-006 in_memread, in_memwrite, in_regwrite  input  1 each  op controls.
REQ-007 in_funct3  input  3  access size/sign (RV64 load/store encoding).
REQ-008 in_rd  input  5  destination register.
REQ-009 in_addr  input  64  effective address (ALU result for memory ops).
REQ-010 in_alu_result  input  64  writeback value for non-load ops.
REQ-011 in_wdata  input  64  store data, right-aligned.
REQ-012 mem_req  output  1; mem_we  output  1; mem_addr  output  64; mem_wdata  output  64; mem_wstrb  output  8.
REQ-013 mem_ack  input  1; mem_rdata  input  64 (valid with mem_ack).
REQ-014 wb_regwrite  output  1; wb_rd  output  5; wb_data  output  64 -- drive register-bank regwrite/register3/datain.
REQ-015 err_misaligned  output  1  one-cycle fault pulse.

Function
REQ-016 FSM SHALL have two states: IDLE, MEM; in_ready = 1 in IDLE only.
REQ-017 Accept in IDLE of non-memory op SHALL register wb_regwrite = in_regwrite && (in_rd != 0), wb_rd, wb_data = in_alu_result next cycle; back-to-back accepts every cycle allowed.
REQ-018 Accept of a legal memory op SHALL latch op fields and enter MEM; no wb pulse that cycle.
REQ-019 In MEM: mem_req = 1, held with stable mem_addr/mem_we/mem_wdata/mem_wstrb until mem_ack sampled high; then return to IDLE.
REQ-020 mem_addr SHALL be {addr[63:3], 3'b000}; byte offset off = addr[2:0].
REQ-021 Store: mem_we = 1; mem_wdata = in_wdata << (8*off); mem_wstrb = sb 8'h01, sh 8'h03, sw 8'h0F, sd 8'hFF, each << off.
REQ-022 Load: mem_we = 0, mem_wstrb = 0; value = mem_rdata >> (8*off), then lb/lh/lw sign-extend, lbu/lhu/lwu zero-extend, ld pass (funct3 000/001/010/100/101/110/011).
REQ-023 Load completion: in the cycle after mem_ack, wb_regwrite = (rd != 0), wb_data = extended value; store completion produces no wb pulse.
REQ-024 wb_regwrite SHALL be a single-cycle pulse per retired instruction; wb_rd/wb_data hold last value otherwise.
REQ-025 Misaligned (lh/lhu off[0]!=0; lw/lwu/sw off[1:0]!=0; ld/sd off!=0), illegal funct3 (load 111, store 1xx), or memread && memwrite SHALL: no memory request, no wb pulse, err_misaligned = 1 next cycle, stay IDLE.
REQ-026 Outside MEM, mem_req SHALL be 0; in_valid while in MEM SHALL be ignored (held upstream).
REQ-027 mem_ack outside MEM SHALL be ignored.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, mem_req = 0, mem_we = 0, mem_wstrb = 0, mem_addr = 0, mem_wdata = 0, wb_regwrite = 0, wb_rd = 0, wb_data = 0, err_misaligned = 0; in_ready = 1 after release.
REQ-029 Reset during MEM SHALL abandon the access with no wb pulse; a late mem_ack is ignored.

Verification
REQ-030 ALU ops rd=5 val 0x11, rd=6 val 0x22 on consecutive cycles -> wb pulses on next two cycles, same order, in_ready constantly 1.
REQ-031 lb addr 0x1003, mem_rdata 0x00000000_80000000 shifted so byte3 = 0x80, ack after 3 cycles -> mem_req held 3 cycles, mem_addr 0x1000, wb_data 0xFFFFFFFFFFFFFF80; lbu same -> 0x80.
REQ-032 sh addr 0x2006, wdata 0xBEEF -> mem_wstrb 8'hC0, mem_wdata 0xBEEF000000000000, mem_we 1, no wb pulse.
REQ-033 lw addr 0x3002 -> err_misaligned pulse, mem_req stays 0, wb_regwrite 0; ld rd=0 -> access done, wb_regwrite 0.
REQ-034 rst_n low mid-MEM, then mem_ack -> mem_req drops immediately, no wb pulse, in_ready 1 after release.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: issues one aligned 64-bit data-memory access per load/store and
// produces a single-cycle register writeback pulse for every retiring instruction.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic        in_regwrite,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_alu_result,
  input  logic [63:0] in_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        wb_regwrite,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        err_misaligned
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StMem  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [2:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [63:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;

  logic        accept;
  logic        is_mem;
  logic        illegal;
  logic [2:0]  in_off;
  logic [7:0]  strb_base;
  logic [63:0] shifted;
  logic [63:0] load_val;

  assign in_ready = (state_q == StIdle);
  assign accept   = in_valid && in_ready;
  assign is_mem   = in_memread || in_memwrite;
  assign in_off   = in_addr[2:0];

  // Size comes from funct3[1:0] for both loads and stores.
  always_comb begin
    illegal = 1'b0;
    if (in_memread && in_memwrite) begin
      illegal = 1'b1;
    end else if (in_memread && (in_funct3 == 3'b111)) begin
      illegal = 1'b1;
    end else if (in_memwrite && in_funct3[2]) begin
      illegal = 1'b1;
    end else begin
      unique case (in_funct3[1:0])
        2'b00:   illegal = 1'b0;
        2'b01:   illegal = in_off[0];
        2'b10:   illegal = (in_off[1:0] != 2'b00);
        default: illegal = (in_off != 3'b000);
      endcase
    end
  end

  always_comb begin
    unique case (in_funct3[1:0])
      2'b00:   strb_base = 8'h01;
      2'b01:   strb_base = 8'h03;
      2'b10:   strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_val = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_val = {56'b0, shifted[7:0]};
      3'b101:  load_val = {48'b0, shifted[15:0]};
      3'b110:  load_val = {32'b0, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    rd_d          = rd_q;
    wb_regwrite_d = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    err_d         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!is_mem) begin
            wb_regwrite_d = in_regwrite && (in_rd != 5'd0);
            wb_rd_d       = in_rd;
            wb_data_d     = in_alu_result;
          end else if (illegal) begin
            err_d = 1'b1;
          end else begin
            state_d  = StMem;
            we_d     = in_memwrite;
            addr_d   = {in_addr[63:3], 3'b000};
            wdata_d  = in_memwrite ? (in_wdata << {in_off, 3'b000}) : 64'd0;
            wstrb_d  = in_memwrite ? (strb_base << in_off) : 8'h00;
            funct3_d = in_funct3;
            off_d    = in_off;
            rd_d     = in_rd;
          end
        end
      end
      default: begin
        if (mem_ack) begin
          state_d = StIdle;
          if (!we_q) begin
            wb_regwrite_d = (rd_q != 5'd0);
            wb_rd_d       = rd_q;
            wb_data_d     = load_val;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      addr_q        <= 64'd0;
      wdata_q       <= 64'd0;
      wstrb_q       <= 8'h00;
      funct3_q      <= 3'd0;
      off_q         <= 3'd0;
      rd_q          <= 5'd0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= 64'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      rd_q          <= rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      err_q         <= err_d;
    end
  end

  // Request and write qualifiers are only asserted while the access is outstanding.
  assign mem_req        = (state_q == StMem);
  assign mem_we         = mem_req && we_q;
  assign mem_wstrb      = mem_req ? wstrb_q : 8'h00;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign wb_regwrite    = wb_regwrite_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign err_misaligned = err_q;

endmodule
